// File: rtl/dc_ipu_bu_texel_source.sv
// Buffering Unit read side: streams 4-texel columns from four line-memory banks through a 2-entry skid FIFO.
// Optional stall statistics are enabled with `define DC_IPU_BU_SRC_STATS_EN.
module dc_ipu_bu_texel_source #(
   parameter int TEX_SIZE_WIDTH = 12,
   parameter int COLOR_WIDTH    = 8,
   localparam int RGB_WIDTH     = 3 * COLOR_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ctl_start,
   input  logic                      ctl_abort,
   input  logic [TEX_SIZE_WIDTH-1:0] ctl_tex_width,
   input  logic [1:0]                ctl_row_rot,
   output logic                      busy,
   output logic                      done,
   output logic                      mem_rd_en,
   output logic [TEX_SIZE_WIDTH-1:0] mem_rd_addr,
   input  logic [RGB_WIDTH-1:0]      mem_rd_data [0:3],
   output logic                      texel_valid,
   input  logic                      texel_ready,
   output logic [RGB_WIDTH-1:0]      texel_data [0:3],
   output logic [15:0]               stat_stall_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [TEX_SIZE_WIDTH-1:0] width_q, width_d;
   logic [TEX_SIZE_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]                rot_q, rot_d;
   logic                      inflight_q, inflight_d;
   logic                      done_q, done_d;
   logic [1:0]                cnt_q, cnt_d;
   logic                      wr_ptr_q, rd_ptr_q;
   logic [RGB_WIDTH-1:0]      fifo_q [0:1][0:3];
   logic [RGB_WIDTH-1:0]      rot_data [0:3];

   logic       pop, push, issue, flush;
   logic [2:0] occ;

   // Credit: FIFO entries plus the read in flight, minus this cycle's pop, must leave room.
   assign texel_valid = (cnt_q != 2'd0);
   assign pop         = texel_valid & texel_ready;
   assign push        = inflight_q;
   assign occ         = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
   assign issue       = (state_q == RUN) && !ctl_abort && (occ < 3'd2);

   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rot_data[i]   = mem_rd_data[2'(i) + rot_q];
         texel_data[i] = fifo_q[rd_ptr_q][i];
      end
   end

   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      rot_d      = rot_q;
      addr_d     = addr_q;
      done_d     = 1'b0;
      inflight_d = issue;
      flush      = 1'b0;
      cnt_d      = cnt_q + 2'(push) - 2'(pop);
      case (state_q)
         IDLE: begin
            if (ctl_start) begin
               width_d = ctl_tex_width;
               rot_d   = ctl_row_rot;
               addr_d  = '0;
               state_d = (ctl_tex_width == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (issue) begin
               addr_d = addr_q + TEX_SIZE_WIDTH'(1);
               if (addr_q == width_q - TEX_SIZE_WIDTH'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Finish when the last entry leaves this cycle so done lands right after the final transfer.
            if (!inflight_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && ctl_abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
         flush   = 1'b1;
         cnt_d   = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         width_q    <= '0;
         addr_q     <= '0;
         rot_q      <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         for (int e = 0; e < 2; e++)
            for (int i = 0; i < 4; i++)
               fifo_q[e][i] <= '0;
      end else begin
         state_q    <= state_d;
         width_q    <= width_d;
         addr_q     <= addr_d;
         rot_q      <= rot_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (push) begin
               for (int i = 0; i < 4; i++) fifo_q[wr_ptr_q][i] <= rot_data[i];
               wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

`ifdef DC_IPU_BU_SRC_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (state_q == IDLE && ctl_start) begin
         stall_q <= '0;
      end else if (texel_valid && !texel_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stat_stall_cnt = stall_q;
`else
   assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dc_ipu_bu_texel_source.sv
// Directed bench for dc_ipu_bu_texel_source: table of line configurations plus abort/reset/start-abort sequences.
module tb_dc_ipu_bu_texel_source;

   localparam int TW = 12;
   localparam int RW = 24;
`ifdef DC_IPU_BU_SRC_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          ctl_start, ctl_abort;
   logic [TW-1:0] ctl_tex_width;
   logic [1:0]    ctl_row_rot;
   logic          busy, done, mem_rd_en;
   logic [TW-1:0] mem_rd_addr;
   logic [RW-1:0] mem_rd_data [0:3];
   logic          texel_valid, texel_ready;
   logic [RW-1:0] texel_data [0:3];
   logic [15:0]   stat_stall_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int width;
      int rot;
      int stall_from;
      int stall_to;
      int exp_done;
      int exp_stalls;
   } vec_t;

   vec_t vecs [6];

   dc_ipu_bu_texel_source dut (
      .clk            (clk),
      .reset          (reset),
      .ctl_start      (ctl_start),
      .ctl_abort      (ctl_abort),
      .ctl_tex_width  (ctl_tex_width),
      .ctl_row_rot    (ctl_row_rot),
      .busy           (busy),
      .done           (done),
      .mem_rd_en      (mem_rd_en),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .texel_valid    (texel_valid),
      .texel_ready    (texel_ready),
      .texel_data     (texel_data),
      .stat_stall_cnt (stat_stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] bank_val(input int b, input int a);
      logic [7:0] a8;
      a8 = 8'(a);
      return {a8, 4'(b), 4'hC, a8 ^ 8'h5A};
   endfunction

   // Line memory: 1-cycle latency, junk when not read so stale captures show up.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         mem_rd_data[b] <= mem_rd_en ? bank_val(b, int'(mem_rd_addr)) : (24'hBAD000 | 24'(b));
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_line(input int w, input int rot, input int sf, input int st,
                           input int exp_done, input int exp_stalls);
      int cyc, n_iss, n_xfer, first_iss, first_val, done_cyc, done_cnt, max_ahead, busy_at_done;
      bit fin;
      n_iss = 0; n_xfer = 0; first_iss = -1; first_val = -1;
      done_cyc = -1; done_cnt = 0; max_ahead = 0; busy_at_done = 1; fin = 1'b0;
      @(posedge clk); #1;
      ctl_start     = 1'b1;
      ctl_tex_width = TW'(w);
      ctl_row_rot   = 2'(rot);
      texel_ready   = !(0 >= sf && 0 <= st);
      cyc = 0;
      while (!fin) begin
         @(negedge clk);
         if (mem_rd_en) begin
            if (first_iss < 0) first_iss = cyc;
            check("rd_addr", longint'(mem_rd_addr), n_iss);
            n_iss++;
         end
         if (texel_valid) begin
            if (first_val < 0) first_val = cyc;
            for (int i = 0; i < 4; i++)
               check($sformatf("lane%0d col%0d", i, n_xfer), longint'(texel_data[i]),
                     longint'(bank_val((i + rot) % 4, n_xfer)));
            if (texel_ready) n_xfer++;
         end
         if (n_iss - n_xfer > max_ahead) max_ahead = n_iss - n_xfer;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc     = cyc;
               busy_at_done = int'(busy);
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) fin = 1'b1;
         if (cyc >= 80) fin = 1'b1;
         @(posedge clk); #1;
         cyc++;
         ctl_start   = 1'b0;
         texel_ready = !(cyc >= sf && cyc <= st);
      end
      texel_ready = 1'b1;
      check($sformatf("w%0d issues", w), n_iss, w);
      check($sformatf("w%0d transfers", w), n_xfer, w);
      check($sformatf("w%0d done cycle", w), done_cyc, exp_done);
      check($sformatf("w%0d done pulses", w), done_cnt, 1);
      check($sformatf("w%0d busy at done", w), busy_at_done, 0);
      check($sformatf("w%0d reads ahead<=2", w), longint'(max_ahead <= 2), 1);
      check($sformatf("w%0d first rd_en cycle", w), first_iss, (w > 0) ? 1 : -1);
      check($sformatf("w%0d first valid cycle", w), first_val, (w > 0) ? 3 : -1);
      check($sformatf("w%0d stall count", w), longint'(stat_stall_cnt), STATS_EN ? exp_stalls : 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, longint'(busy), 0);
      check({tag, " done"}, longint'(done), 0);
      check({tag, " mem_rd_en"}, longint'(mem_rd_en), 0);
      check({tag, " mem_rd_addr"}, longint'(mem_rd_addr), 0);
      check({tag, " texel_valid"}, longint'(texel_valid), 0);
      check({tag, " stat"}, longint'(stat_stall_cnt), 0);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s texel_data%0d", tag, i), longint'(texel_data[i]), 0);
   endtask

   initial begin
      vecs[0] = '{width: 3, rot: 0, stall_from: -1, stall_to: -1, exp_done: 6,  exp_stalls: 0};
      vecs[1] = '{width: 4, rot: 2, stall_from: -1, stall_to: -1, exp_done: 7,  exp_stalls: 0};
      vecs[2] = '{width: 8, rot: 1, stall_from: 3,  stall_to: 9,  exp_done: 18, exp_stalls: 7};
      vecs[3] = '{width: 0, rot: 0, stall_from: -1, stall_to: -1, exp_done: 2,  exp_stalls: 0};
      vecs[4] = '{width: 1, rot: 3, stall_from: -1, stall_to: -1, exp_done: 4,  exp_stalls: 0};
      vecs[5] = '{width: 4, rot: 0, stall_from: 4,  stall_to: 5,  exp_done: 9,  exp_stalls: 2};

      reset = 1'b1; ctl_start = 1'b0; ctl_abort = 1'b0;
      ctl_tex_width = '0; ctl_row_rot = '0; texel_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      for (int v = 0; v < 6; v++)
         run_line(vecs[v].width, vecs[v].rot, vecs[v].stall_from, vecs[v].stall_to,
                  vecs[v].exp_done, vecs[v].exp_stalls);

      // Abort mid-line; a start during RUN must be ignored.
      @(posedge clk); #1;
      ctl_start = 1'b1; ctl_tex_width = TW'(10); ctl_row_rot = 2'd0; texel_ready = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         ctl_start     = (c == 3);
         ctl_tex_width = (c == 3) ? TW'(1) : TW'(10);
         ctl_abort     = (c == 5);
         @(negedge clk);
         if (c == 4) begin
            check("abort run rd_en c4", longint'(mem_rd_en), 1);
            check("abort run addr c4", longint'(mem_rd_addr), 3);
         end
         if (c >= 6) begin
            check($sformatf("abort busy c%0d", c), longint'(busy), 0);
            check($sformatf("abort valid c%0d", c), longint'(texel_valid), 0);
            check($sformatf("abort done c%0d", c), longint'(done), 0);
            check($sformatf("abort rd_en c%0d", c), longint'(mem_rd_en), 0);
         end
      end
      ctl_start = 1'b0; ctl_abort = 1'b0;
      run_line(2, 1, -1, -1, 5, 0);

      // Reset in cycle 4 of a width-6 line.
      @(posedge clk); #1;
      ctl_start = 1'b1; ctl_tex_width = TW'(6); ctl_row_rot = 2'd1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         ctl_start = 1'b0;
         reset     = (c == 4);
      end
      @(negedge clk);
      check_reset_outputs("midline reset");
      run_line(3, 0, -1, -1, 6, 0);

      // Start and abort together in IDLE: start wins.
      @(posedge clk); #1;
      ctl_start = 1'b1; ctl_abort = 1'b1; ctl_tex_width = TW'(2); ctl_row_rot = 2'd0;
      @(posedge clk); #1;
      ctl_start = 1'b0; ctl_abort = 1'b0;
      @(negedge clk);
      check("start+abort busy", longint'(busy), 1);
      check("start+abort rd_en", longint'(mem_rd_en), 1);
      begin
         int n;
         n = 0;
         while (busy && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("start+abort line ends", longint'(busy), 0);
      end

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
